// File: rtl/phys_reg_free_list_if.sv
// Rename/retire-side bundle for the physical register free list.
// The master side is the pipeline (rename requests, retire frees); the slave side is the list.
interface phys_reg_free_list_if #(
  parameter int PREG_W = 6,
  parameter int CNT_W  = 6
);
  logic              alloc_req_a;
  logic              alloc_req_b;
  logic [PREG_W-1:0] alloc_preg_a;
  logic [PREG_W-1:0] alloc_preg_b;
  logic              alloc_stall;
  logic              free_valid_a;
  logic [PREG_W-1:0] free_preg_a;
  logic              free_valid_b;
  logic [PREG_W-1:0] free_preg_b;
  logic [CNT_W-1:0]  free_count;
  logic              overflow_err;

  modport master (
    output alloc_req_a, alloc_req_b, free_valid_a, free_preg_a, free_valid_b, free_preg_b,
    input  alloc_preg_a, alloc_preg_b, alloc_stall, free_count, overflow_err
  );

  modport slave (
    input  alloc_req_a, alloc_req_b, free_valid_a, free_preg_a, free_valid_b, free_preg_b,
    output alloc_preg_a, alloc_preg_b, alloc_stall, free_count, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: two rename allocations and two
// retire frees per cycle, with all-or-nothing stall and sticky overflow flag.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
  parameter int PREG_W    = $clog2(NUM_PREGS),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  phys_reg_free_list_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PREG_W-1:0] entry_q [DEPTH];
  logic [PREG_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [1:0]        nreq, granted, nfree;
  logic              stall;
  logic [PTR_W-1:0]  head_p1, tail_p1;
  logic              acc_a, acc_b, keep_a, keep_b;
  logic [CNT_W-1:0]  avail, room;

  // Wrap by compare so DEPTH need not be a power of two; n <= 2 <= DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W+1:0] s;
    s = {2'b00, p} + {{PTR_W{1'b0}}, n};
    if (s >= (PTR_W+2)'(DEPTH)) s = s - (PTR_W+2)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    nreq    = {1'b0, bus.alloc_req_a} + {1'b0, bus.alloc_req_b};
    stall   = CNT_W'(nreq) > count_q;
    granted = stall ? 2'd0 : nreq;
    head_p1 = ptr_add(head_q, 2'd1);
    tail_p1 = ptr_add(tail_q, 2'd1);
    head_d  = ptr_add(head_q, granted);

    acc_a  = bus.free_valid_a && (bus.free_preg_a != '0);
    acc_b  = bus.free_valid_b && (bus.free_preg_b != '0);
    avail  = count_q - CNT_W'(granted);
    room   = CNT_W'(DEPTH) - avail;
    keep_a = acc_a && (room != '0);
    keep_b = acc_b && (keep_a ? (room >= CNT_W'(2)) : (room != '0));
    nfree  = {1'b0, keep_a} + {1'b0, keep_b};

    // Offers come from entry_q, so a same-edge write at tail==head cannot bypass.
    entry_d = entry_q;
    if (keep_a) entry_d[tail_q] = bus.free_preg_a;
    if (keep_b) entry_d[keep_a ? tail_p1 : tail_q] = bus.free_preg_b;

    tail_d  = ptr_add(tail_q, nfree);
    count_d = avail + CNT_W'(nfree);
    ovf_d   = ovf_q | (acc_a & ~keep_a) | (acc_b & ~keep_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= PREG_W'(NUM_AREGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
      ovf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.alloc_preg_a = entry_q[head_q];
  assign bus.alloc_preg_b = (bus.alloc_req_b && !bus.alloc_req_a) ? entry_q[head_q] : entry_q[head_p1];
  assign bus.alloc_stall  = stall;
  assign bus.free_count   = count_q;
  assign bus.overflow_err = ovf_q;

  // Double-free detection: the retire stage must never return a tag already listed.
  function automatic logic live(input int i);
    int d;
    d = i - int'(head_q);
    if (d < 0) d = d + DEPTH;
    return d < int'(count_q);
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.free_valid_a && bus.free_valid_b) assert (bus.free_preg_a != bus.free_preg_b);
      for (int i = 0; i < DEPTH; i++) begin
        if (live(i)) begin
          if (keep_a) assert (entry_q[i] != bus.free_preg_a);
          if (keep_b) assert (entry_q[i] != bus.free_preg_b);
        end
      end
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: reset, pair/single allocation, stall,
// free filtering and overflow, wrap-around FIFO order and async reset.
module tb_phys_reg_free_list;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  phys_reg_free_list_if #(.PREG_W(6), .CNT_W(6)) bus ();

  phys_reg_free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic drive(input logic ra, input logic rb, input logic va, input logic [5:0] pa,
                       input logic vb, input logic [5:0] pb);
    bus.alloc_req_a  = ra;
    bus.alloc_req_b  = rb;
    bus.free_valid_a = va;
    bus.free_preg_a  = pa;
    bus.free_valid_b = vb;
    bus.free_preg_b  = pb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (bus.alloc_preg_a !== 6'd32) begin n_err++; $display("FAIL reset_preg_a: got %0d want 32", bus.alloc_preg_a); end
    n_vec++; if (bus.alloc_preg_b !== 6'd33) begin n_err++; $display("FAIL reset_preg_b: got %0d want 33", bus.alloc_preg_b); end
    n_vec++; if (bus.alloc_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", bus.alloc_stall); end
    n_vec++; if (bus.free_count !== 6'd32) begin n_err++; $display("FAIL reset_count: got %0d want 32", bus.free_count); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", bus.overflow_err); end
  endtask

  task automatic test_alloc_pair();
    do_reset();
    drive(1, 1, 0, 0, 0, 0); #1;
    n_vec++; if (bus.alloc_preg_a !== 6'd32 || bus.alloc_preg_b !== 6'd33 || bus.alloc_stall !== 1'b0) begin
      n_err++; $display("FAIL pair_grant: got a=%0d b=%0d stall=%0b want 32 33 0", bus.alloc_preg_a, bus.alloc_preg_b, bus.alloc_stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.alloc_preg_a !== 6'd34 || bus.alloc_preg_b !== 6'd35) begin
      n_err++; $display("FAIL pair_next_offer: got a=%0d b=%0d want 34 35", bus.alloc_preg_a, bus.alloc_preg_b); end
    n_vec++; if (bus.free_count !== 6'd30) begin n_err++; $display("FAIL pair_count: got %0d want 30", bus.free_count); end
    drive(0, 1, 0, 0, 0, 0); #1;
    n_vec++; if (bus.alloc_preg_b !== 6'd34) begin n_err++; $display("FAIL only_b_offer: got %0d want 34", bus.alloc_preg_b); end
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd29 || bus.alloc_preg_a !== 6'd35 || bus.alloc_preg_b !== 6'd36) begin
      n_err++; $display("FAIL only_b_after: got cnt=%0d a=%0d b=%0d want 29 35 36", bus.free_count, bus.alloc_preg_a, bus.alloc_preg_b); end
  endtask

  task automatic test_drain_empty();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, 0, 0, 0); #1;
      n_vec++; if (bus.alloc_preg_a !== 6'(32 + 2*i) || bus.alloc_preg_b !== 6'(33 + 2*i) || bus.alloc_stall !== 1'b0) begin
        n_err++; $display("FAIL drain_grant[%0d]: got a=%0d b=%0d stall=%0b want %0d %0d 0", i, bus.alloc_preg_a, bus.alloc_preg_b, bus.alloc_stall, 32+2*i, 33+2*i); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd0) begin n_err++; $display("FAIL drain_count: got %0d want 0", bus.free_count); end
    drive(1, 0, 1, 6'd40, 0, 0); #1;
    n_vec++; if (bus.alloc_stall !== 1'b1) begin n_err++; $display("FAIL empty_stall: got %0b want 1", bus.alloc_stall); end
    tick();
    drive(1, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.alloc_stall !== 1'b0 || bus.alloc_preg_a !== 6'd40 || bus.free_count !== 6'd1) begin
      n_err++; $display("FAIL empty_refill: got stall=%0b a=%0d cnt=%0d want 0 40 1", bus.alloc_stall, bus.alloc_preg_a, bus.free_count); end
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd0) begin n_err++; $display("FAIL empty_realloc_count: got %0d want 0", bus.free_count); end
  endtask

  task automatic test_stall_pair();
    do_reset();
    for (int i = 0; i < 15; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd1 || bus.alloc_stall !== 1'b1) begin
      n_err++; $display("FAIL one_left_stall: got cnt=%0d stall=%0b want 1 1", bus.free_count, bus.alloc_stall); end
    tick(); #1;
    n_vec++; if (bus.free_count !== 6'd1 || bus.alloc_preg_a !== 6'd63) begin
      n_err++; $display("FAIL one_left_hold: got cnt=%0d a=%0d want 1 63", bus.free_count, bus.alloc_preg_a); end
    drive(1, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.alloc_stall !== 1'b0 || bus.alloc_preg_a !== 6'd63) begin
      n_err++; $display("FAIL one_left_single: got stall=%0b a=%0d want 0 63", bus.alloc_stall, bus.alloc_preg_a); end
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd0) begin n_err++; $display("FAIL one_left_after: got %0d want 0", bus.free_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.overflow_err !== 1'b0 || bus.free_count !== 6'd32) begin
      n_err++; $display("FAIL zero_tag_full: got ovf=%0b cnt=%0d want 0 32", bus.overflow_err, bus.free_count); end
    drive(0, 0, 1, 6'd5, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.overflow_err !== 1'b1 || bus.free_count !== 6'd32) begin
      n_err++; $display("FAIL full_free_drop: got ovf=%0b cnt=%0d want 1 32", bus.overflow_err, bus.free_count); end
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 6'd0); tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.overflow_err !== 1'b1 || bus.free_count !== 6'd31) begin
      n_err++; $display("FAIL zero_tag_sticky: got ovf=%0b cnt=%0d want 1 31", bus.overflow_err, bus.free_count); end

    // One slot of room: a lands, b is the one dropped.
    do_reset();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 6'd1, 1, 6'd2); tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.overflow_err !== 1'b1 || bus.free_count !== 6'd32) begin
      n_err++; $display("FAIL partial_drop: got ovf=%0b cnt=%0d want 1 32", bus.overflow_err, bus.free_count); end
    for (int i = 0; i < 15; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    drive(1, 1, 0, 0, 0, 0); #1;
    n_vec++; if (bus.alloc_preg_a !== 6'd63 || bus.alloc_preg_b !== 6'd1) begin
      n_err++; $display("FAIL partial_kept_tag: got a=%0d b=%0d want 63 1", bus.alloc_preg_a, bus.alloc_preg_b); end
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd0) begin n_err++; $display("FAIL partial_drain: got %0d want 0", bus.free_count); end
  endtask

  task automatic test_wrap();
    logic [5:0] q[$];
    logic [5:0] ta, tb;
    int s;
    do_reset();
    for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
    s = 0;
    for (int p = 0; p < 40; p++) begin
      ta = 6'((s % 63) + 1);
      tb = 6'(((s + 1) % 63) + 1);
      s = s + 2;
      drive(1, 1, 1, ta, 1, tb); #1;
      n_vec++; if (bus.alloc_preg_a !== q[0] || bus.alloc_preg_b !== q[1] || bus.alloc_stall !== 1'b0) begin
        n_err++; $display("FAIL wrap_offer[%0d]: got a=%0d b=%0d stall=%0b want %0d %0d 0", p, bus.alloc_preg_a, bus.alloc_preg_b, bus.alloc_stall, q[0], q[1]); end
      void'(q.pop_front());
      void'(q.pop_front());
      q.push_back(ta);
      q.push_back(tb);
      tick();
      n_vec++; if (bus.free_count !== 6'd32) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 32", p, bus.free_count); end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 1, 6'd5, 0, 0); tick();
    for (int i = 0; i < 12; i++) begin drive(1, 1, 0, 0, 0, 0); tick(); end
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 6'd3, 0, 0); #1;
    n_vec++; if (bus.free_count !== 6'd7 || bus.overflow_err !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_state: got cnt=%0d ovf=%0b want 7 1", bus.free_count, bus.overflow_err); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.free_count !== 6'd32 || bus.overflow_err !== 1'b0) begin
      n_err++; $display("FAIL async_reset_state: got cnt=%0d ovf=%0b want 32 0", bus.free_count, bus.overflow_err); end
    n_vec++; if (bus.alloc_preg_a !== 6'd32 || bus.alloc_preg_b !== 6'd33) begin
      n_err++; $display("FAIL async_reset_offer: got a=%0d b=%0d want 32 33", bus.alloc_preg_a, bus.alloc_preg_b); end
    tick();
    n_vec++; if (bus.free_count !== 6'd32) begin n_err++; $display("FAIL reset_held_count: got %0d want 32", bus.free_count); end
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.free_count !== 6'd32 || bus.alloc_preg_a !== 6'd32) begin
      n_err++; $display("FAIL post_reset_idle: got cnt=%0d a=%0d want 32 32", bus.free_count, bus.alloc_preg_a); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    test_reset();
    test_alloc_pair();
    test_drain_empty();
    test_stall_pair();
    test_overflow();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
